// File: rtl/sar_search_ctrl_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
//   state_t      : controller state encoding
//   DefaultWidth : default operand width
//   flags_legal  : true when exactly one comparator flag is asserted
package sar_search_ctrl_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StProbe = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } state_t;

    function automatic logic flags_legal(input logic gre, input logic less, input logic eq);
        return (gre ^ less ^ eq) & ~(gre & less & eq);
    endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Handshake bundle between the search controller and its environment.
//   start               : request a new search (environment -> controller)
//   cmp_gre/less/eq     : comparator flags for target vs. probe (environment -> controller)
//   probe               : current trial value (controller -> comparator b)
//   busy/done           : search in progress / one-cycle completion pulse
//   found/err/result    : search outcome, held until the next accepted start
interface sar_search_ctrl_if #(
    parameter int unsigned WIDTH = sar_search_ctrl_pkg::DefaultWidth
) ();
    logic             start;
    logic             cmp_gre;
    logic             cmp_less;
    logic             cmp_eq;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic             found;
    logic             err;
    logic [WIDTH-1:0] result;

    // Controller side.
    modport master (
        input  start, cmp_gre, cmp_less, cmp_eq,
        output probe, busy, done, found, err, result
    );

    // Environment side: requester plus comparator.
    modport slave (
        output start, cmp_gre, cmp_less, cmp_eq,
        input  probe, busy, done, found, err, result
    );
endinterface

// File: rtl/relational_op.sv
// Combinational unsigned magnitude comparator used as the search responder.
//   a, b           : operands (a is the unknown target, b the probe)
//   gre, less, eq  : a > b, a < b, a == b
module relational_op #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gre,
    output logic             less,
    output logic             eq
);
    assign gre  = a > b;
    assign less = a < b;
    assign eq   = a == b;
endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search initiator. Drives MSB-first trial values on probe,
// reads the comparator flags back each cycle and converges on the target.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start request, comparator flags in; probe, busy, done, found, err, result out
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sar_search_ctrl_if.master     bus
);
    localparam int unsigned      IdxW   = $clog2(WIDTH);
    localparam logic [IdxW-1:0]  MsbIdx = IdxW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    state_t            state_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  probe_q;
    logic [WIDTH-1:0]  result_q;
    logic [IdxW-1:0]   bit_idx_q;
    logic              busy_q;
    logic              done_q;
    logic              found_q;
    logic              err_q;

    logic              flags_ok;
    logic [WIDTH-1:0]  kept_acc;

    assign flags_ok = flags_legal(bus.cmp_gre, bus.cmp_less, bus.cmp_eq);
    // probe already carries the trial bit, so keeping it is just taking probe.
    assign kept_acc = bus.cmp_gre ? probe_q : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            probe_q   <= '0;
            result_q  <= '0;
            bit_idx_q <= MsbIdx;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q   <= StProbe;
                        probe_q   <= One << MsbIdx;
                        acc_q     <= '0;
                        bit_idx_q <= MsbIdx;
                        found_q   <= 1'b0;
                        err_q     <= 1'b0;
                        result_q  <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StProbe: begin
                    if (!flags_ok) begin
                        state_q  <= StDone;
                        err_q    <= 1'b1;
                        found_q  <= 1'b0;
                        result_q <= acc_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (bus.cmp_eq) begin
                        state_q  <= StDone;
                        found_q  <= 1'b1;
                        result_q <= probe_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (bit_idx_q != '0) begin
                        acc_q     <= kept_acc;
                        bit_idx_q <= bit_idx_q - 1'b1;
                        probe_q   <= kept_acc | (One << (bit_idx_q - 1'b1));
                    end else begin
                        // All bits decided without a match: confirm acc itself.
                        acc_q   <= kept_acc;
                        probe_q <= kept_acc;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    found_q  <= flags_ok & bus.cmp_eq;
                    err_q    <= ~flags_ok;
                    result_q <= acc_q;
                    state_q  <= StDone;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.probe  = probe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl with a relational_op responder.
// Expected outcomes are pushed when a search is launched and popped on each done pulse.
module tb_sar_search_ctrl;
    localparam int unsigned W = 4;

    typedef struct {
        logic         found;
        logic         err;
        logic [W-1:0] result;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] target;
    logic         c_gre, c_less, c_eq;
    logic         force_en;
    logic         f_gre, f_less, f_eq;

    int           cyc;
    int           errs;
    int           checks;
    int           done_cnt;
    exp_t         sb[$];
    exp_t         e;
    logic [W-1:0] probe_log[$];

    sar_search_ctrl_if #(.WIDTH(W)) bus ();

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    relational_op #(.WIDTH(W)) cmp (
        .a    (target),
        .b    (bus.probe),
        .gre  (c_gre),
        .less (c_less),
        .eq   (c_eq)
    );

    assign bus.cmp_gre  = force_en ? f_gre  : c_gre;
    assign bus.cmp_less = force_en ? f_less : c_less;
    assign bus.cmp_eq   = force_en ? f_eq   : c_eq;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
        end
    endtask

    // Plain MSB-first bisection; k is the number of cycles from the start edge to done.
    task automatic model_search(input logic [W-1:0] tgt, output logic fnd,
                                output logic [W-1:0] res, output int k);
        int unsigned acc;
        int unsigned trial;
        acc = 0;
        for (int i = W - 1; i >= 0; i--) begin
            trial = acc + (1 << i);
            if (trial == int'(tgt)) begin
                fnd = 1'b1;
                res = W'(trial);
                k   = W - i;
                return;
            end
            if (int'(tgt) > trial) acc = trial;
        end
        fnd = (acc == int'(tgt));
        res = W'(acc);
        k   = W + 1;
    endtask

    // Pulses start for one cycle; se is the cycle number of the accepting edge.
    task automatic start_search(input logic [W-1:0] tgt, input bit push, output int se);
        exp_t x;
        int   k;
        target = tgt;
        @(posedge clk);
        #1 bus.start = 1'b1;
        probe_log.delete();
        @(posedge clk);
        #1 bus.start = 1'b0;
        se = cyc;
        if (push) begin
            model_search(tgt, x.found, x.result, k);
            x.err = 1'b0;
            x.cyc = se + k;
            sb.push_back(x);
        end
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > base) begin
                check_eq("done_pulse_width", int'(bus.done), 0);
                return;
            end
        end
        check_eq("done_timeout", 0, 1);
    endtask

    task automatic check_probes(input string tag, input int n, input int e0, input int e1,
                                input int e2, input int e3, input int e4);
        int ev[5];
        ev = '{e0, e1, e2, e3, e4};
        check_eq({tag, "_count"}, probe_log.size(), n);
        for (int i = 0; i < n && i < probe_log.size(); i++)
            check_eq(tag, int'(probe_log[i]), ev[i]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) probe_log.push_back(bus.probe);
            if (bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("found", int'(bus.found), int'(e.found));
                    check_eq("err", int'(bus.err), int'(e.err));
                    check_eq("result", int'(bus.result), int'(e.result));
                    check_eq("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int   se;
        int   base;
        exp_t x;

        errs = 0; checks = 0; done_cnt = 0;
        rst_n = 1'b0; bus.start = 1'b0; target = '0;
        force_en = 1'b0; f_gre = 1'b0; f_less = 1'b0; f_eq = 1'b0;

        #3;
        check_eq("rst_probe", int'(bus.probe), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.done), 0);
        check_eq("rst_result", int'(bus.result), 0);
        #9 rst_n = 1'b1;

        // Early match on trial 4.
        base = done_cnt;
        start_search(4'd9, 1'b1, se);
        wait_done(base);
        check_probes("probes_t9", 4, 8, 12, 10, 9, 0);

        // Full search ending in CHECK with a match on zero.
        base = done_cnt;
        start_search(4'd0, 1'b1, se);
        wait_done(base);
        check_probes("probes_t0", 5, 8, 4, 2, 1, 0);

        // Match on the very first trial.
        base = done_cnt;
        start_search(4'd8, 1'b1, se);
        wait_done(base);
        check_probes("probes_t8", 1, 8, 0, 0, 0, 0);

        // Top value.
        base = done_cnt;
        start_search(4'd15, 1'b1, se);
        wait_done(base);
        check_probes("probes_t15", 4, 8, 12, 14, 15, 0);

        // A start pulse while busy must be ignored.
        base = done_cnt;
        start_search(4'd10, 1'b1, se);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(base);
        repeat (10) @(posedge clk);
        #1;
        check_eq("single_done", done_cnt - base, 1);
        check_eq("result_hold", int'(bus.result), 10);

        // Illegal flags (gre and less) on the second trial.
        base = done_cnt;
        start_search(4'd12, 1'b0, se);
        x.found = 1'b0; x.err = 1'b1; x.result = 4'd8; x.cyc = se + 2;
        sb.push_back(x);
        @(posedge clk);
        #1 begin force_en = 1'b1; f_gre = 1'b1; f_less = 1'b1; f_eq = 1'b0; end
        @(posedge clk);
        #1 force_en = 1'b0;
        wait_done(base);

        // Asynchronous reset mid-search abandons it.
        base = done_cnt;
        start_search(4'd9, 1'b1, se);
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        check_eq("arst_probe", int'(bus.probe), 0);
        check_eq("arst_busy", int'(bus.busy), 0);
        check_eq("arst_err", int'(bus.err), 0);
        check_eq("arst_result", int'(bus.result), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_eq("no_done_after_reset", done_cnt - base, 0);

        base = done_cnt;
        start_search(4'd5, 1'b1, se);
        wait_done(base);

        // Target moves while CHECK is evaluating: mismatch without error.
        base = done_cnt;
        start_search(4'd0, 1'b0, se);
        x.found = 1'b0; x.err = 1'b0; x.result = 4'd0; x.cyc = se + 5;
        sb.push_back(x);
        repeat (4) @(posedge clk);
        #1 target = 4'd7;
        wait_done(base);

        check_eq("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
